rf_wb_arbiter: RTL and testbench

Shares the register file's single write port between several writeback sources (ALU, load unit, CSR unit). Each cycle it picks one valid request round-robin, returns a ready to that source, and presents the request on the register file write port one cycle later from a registered output stage. Writes to x0 are accepted and discarded, so no source needs to special-case them.

---
 rtl/rf_pkg.sv | 14 +
 rtl/rr_arbiter.sv | 37 +++
 rtl/rf_wb_arbiter.sv | 66 ++++++
 tb/tb_rf_wb_arbiter.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/rf_pkg.sv
// Register file shared definitions.
// Widths and the writeback request bundle used by the RF and its writers.
package rf_pkg;

  localparam int REG_ADDR_W = 5;
  localparam int NUM_REGS   = 32;
  localparam int XLEN       = 32;

  typedef struct packed {
    logic [REG_ADDR_W-1:0] addr;
    logic [XLEN-1:0]       data;
  } wb_req_t;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: req/ptr/enable in,
// one-hot grant, encoded index and any_grant out.
module rr_arbiter #(
  parameter int NUM_SRC = 3,
  parameter int IW      = $clog2(NUM_SRC)
) (
  input  logic [NUM_SRC-1:0] req,
  input  logic [IW-1:0]      ptr,
  input  logic               enable,
  output logic [NUM_SRC-1:0] grant,
  output logic [IW-1:0]      idx,
  output logic               any_grant
);

  logic          found;
  logic [IW-1:0] j;

  // Scan from ptr upward, wrapping; first requester wins.
  always_comb begin
    grant = '0;
    idx   = '0;
    found = 1'b0;
    j     = '0;
    for (int k = 0; k < NUM_SRC; k++) begin
      j = IW'((int'(ptr) + k) % NUM_SRC);
      if (!found && req[j]) begin
        found = 1'b1;
        idx   = j;
      end
    end
    if (found && enable) begin
      grant[idx] = 1'b1;
    end
    any_grant = found && enable;
  end

endmodule

// File: rtl/rf_wb_arbiter.sv
// Shares the RF write port among writeback sources, round-robin,
// with a registered rf_write_* stage and silent discard of x0 writes.
module rf_wb_arbiter
  import rf_pkg::*;
#(
  parameter int N       = 32,
  parameter int NUM_SRC = 3,
  parameter int IW      = $clog2(NUM_SRC)
) (
  input  logic                                clk,
  input  logic                                reset,
  input  logic [NUM_SRC-1:0]                  src_valid,
  input  logic [NUM_SRC-1:0][REG_ADDR_W-1:0]  src_addr,
  input  logic [NUM_SRC-1:0][N-1:0]           src_data,
  output logic [NUM_SRC-1:0]                  src_ready,
  input  logic                                wb_hold,
  output logic                                rf_write_en,
  output logic [REG_ADDR_W-1:0]               rf_write_add,
  output logic [N-1:0]                        rf_write_data,
  output logic [IW-1:0]                       grant_id,
  output logic                                x0_drop
);

  logic [IW-1:0]         rr_ptr;
  logic [IW-1:0]         win;
  logic                  xfer;
  logic [REG_ADDR_W-1:0] win_addr;
  logic [IW-1:0]         ptr_next;

  // Reset gates grants so no source sees ready while in reset.
  rr_arbiter #(
    .NUM_SRC (NUM_SRC),
    .IW      (IW)
  ) u_arb (
    .req       (src_valid),
    .ptr       (rr_ptr),
    .enable    (!wb_hold && !reset),
    .grant     (src_ready),
    .idx       (win),
    .any_grant (xfer)
  );

  assign win_addr = src_addr[win];
  assign ptr_next = (win == IW'(NUM_SRC - 1)) ? '0 : win + IW'(1);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rr_ptr        <= '0;
      rf_write_en   <= 1'b0;
      x0_drop       <= 1'b0;
      rf_write_add  <= '0;
      rf_write_data <= '0;
      grant_id      <= '0;
    end else begin
      rf_write_en <= xfer && (win_addr != '0);
      x0_drop     <= xfer && (win_addr == '0);
      if (xfer) begin
        rr_ptr        <= ptr_next;
        rf_write_add  <= win_addr;
        rf_write_data <= src_data[win];
        grant_id      <= win;
      end
    end
  end

endmodule

// File: tb/tb_rf_wb_arbiter.sv
// Self-checking bench for rf_wb_arbiter: directed vector table,
// hand sequences for reset/round-robin, and a randomized model run.
module tb_rf_wb_arbiter;
  import rf_pkg::*;

  localparam int NS = 3;

  logic                 clk = 1'b0;
  logic                 reset;
  logic [NS-1:0]        src_valid;
  logic [NS-1:0][4:0]   src_addr;
  logic [NS-1:0][31:0]  src_data;
  logic [NS-1:0]        src_ready;
  logic                 wb_hold;
  logic                 rf_write_en;
  logic [4:0]           rf_write_add;
  logic [31:0]          rf_write_data;
  logic [1:0]           grant_id;
  logic                 x0_drop;

  int checks   = 0;
  int failures = 0;

  rf_wb_arbiter #(.N(32), .NUM_SRC(NS)) dut (
    .clk           (clk),
    .reset         (reset),
    .src_valid     (src_valid),
    .src_addr      (src_addr),
    .src_data      (src_data),
    .src_ready     (src_ready),
    .wb_hold       (wb_hold),
    .rf_write_en   (rf_write_en),
    .rf_write_add  (rf_write_add),
    .rf_write_data (rf_write_data),
    .grant_id      (grant_id),
    .x0_drop       (x0_drop)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  typedef struct {
    logic [2:0]  v;
    logic [4:0]  a0, a1, a2;
    logic [31:0] d0, d1, d2;
    logic        hold;
    logic [2:0]  rdy;
    logic        en, x0;
    logic [4:0]  add;
    logic [31:0] dat;
    logic [1:0]  gid;
  } vec_t;

  vec_t tbl[12];

  task automatic drive(input logic [2:0] v, input logic [4:0] a0,
                       input logic [4:0] a1, input logic [4:0] a2,
                       input logic [31:0] d0, input logic [31:0] d1,
                       input logic [31:0] d2, input logic h);
    src_valid = v;
    src_addr[0] = a0; src_addr[1] = a1; src_addr[2] = a2;
    src_data[0] = d0; src_data[1] = d1; src_data[2] = d2;
    wb_hold = h;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    drive(3'b000, 0, 0, 0, 0, 0, 0, 1'b0);
    @(negedge clk);
    reset = 1'b0;
  endtask

  // Randomized-run model state
  wb_req_t     rq[NS];
  logic [NS-1:0] mv;
  int          mptr;
  int          wait_c[NS];
  int          max_wait;
  logic [4:0]  m_add;
  logic [31:0] m_dat;
  logic [1:0]  m_gid;

  initial begin
    reset = 1'b1;
    drive(3'b000, 0, 0, 0, 0, 0, 0, 1'b0);

    // Reset held: everything zero, no ready.
    #12;
    chk("rst_ready", src_ready, 0);
    chk("rst_en", rf_write_en, 0);
    chk("rst_add", rf_write_add, 0);
    chk("rst_data", rf_write_data, 0);
    chk("rst_gid", grant_id, 0);
    chk("rst_x0", x0_drop, 0);
    @(negedge clk);
    reset = 1'b0;

    // Directed table, applied in order from reset (rr_ptr = 0).
    tbl[0]  = '{3'b000, 0, 0, 0, 0, 0, 0, 0,
                3'b000, 0, 0, 0, 0, 0};
    tbl[1]  = '{3'b010, 0, 5, 0, 0, 32'hDEADBEEF, 0, 0,
                3'b010, 1, 0, 5, 32'hDEADBEEF, 1};
    tbl[2]  = '{3'b111, 1, 2, 3, 32'hA0, 32'hA1, 32'hA2, 0,
                3'b100, 1, 0, 3, 32'hA2, 2};
    tbl[3]  = '{3'b111, 1, 2, 3, 32'hA0, 32'hA1, 32'hA2, 0,
                3'b001, 1, 0, 1, 32'hA0, 0};
    tbl[4]  = '{3'b111, 1, 2, 3, 32'hA0, 32'hA1, 32'hA2, 0,
                3'b010, 1, 0, 2, 32'hA1, 1};
    tbl[5]  = '{3'b111, 1, 2, 3, 32'hA0, 32'hA1, 32'hA2, 1,
                3'b000, 0, 0, 2, 32'hA1, 1};
    tbl[6]  = '{3'b111, 1, 2, 3, 32'hA0, 32'hA1, 32'hA2, 1,
                3'b000, 0, 0, 2, 32'hA1, 1};
    tbl[7]  = '{3'b111, 1, 2, 3, 32'hA0, 32'hA1, 32'hA2, 0,
                3'b100, 1, 0, 3, 32'hA2, 2};
    tbl[8]  = '{3'b001, 0, 0, 0, 32'h1234, 0, 0, 0,
                3'b001, 0, 1, 0, 32'h1234, 0};
    tbl[9]  = '{3'b011, 4, 6, 0, 32'hB0, 32'hB1, 0, 0,
                3'b010, 1, 0, 6, 32'hB1, 1};
    tbl[10] = '{3'b001, 4, 0, 0, 32'hB0, 0, 0, 0,
                3'b001, 1, 0, 4, 32'hB0, 0};
    tbl[11] = '{3'b000, 0, 0, 0, 0, 0, 0, 0,
                3'b000, 0, 0, 4, 32'hB0, 0};

    foreach (tbl[i]) begin
      @(negedge clk);
      drive(tbl[i].v, tbl[i].a0, tbl[i].a1, tbl[i].a2,
            tbl[i].d0, tbl[i].d1, tbl[i].d2, tbl[i].hold);
      #1;
      chk($sformatf("t%0d_ready", i), src_ready, tbl[i].rdy);
      @(posedge clk);
      #1;
      chk($sformatf("t%0d_en", i), rf_write_en, tbl[i].en);
      chk($sformatf("t%0d_x0", i), x0_drop, tbl[i].x0);
      chk($sformatf("t%0d_add", i), rf_write_add, tbl[i].add);
      chk($sformatf("t%0d_data", i), rf_write_data, tbl[i].dat);
      chk($sformatf("t%0d_gid", i), grant_id, tbl[i].gid);
    end

    // From reset, all valid: grants 0,1,2,0,1,2, writes every cycle.
    do_reset();
    for (int c = 0; c < 6; c++) begin
      if (c != 0) @(negedge clk);
      drive(3'b111, 9, 10, 11, 32'hC0, 32'hC1, 32'hC2, 1'b0);
      #1;
      chk($sformatf("rr%0d_ready", c), src_ready, 3'b001 << (c % 3));
      @(posedge clk);
      #1;
      chk($sformatf("rr%0d_en", c), rf_write_en, 1);
      chk($sformatf("rr%0d_gid", c), grant_id, c % 3);
    end

    // Reset right after src 2 is granted (addr 7): write is dropped.
    do_reset();
    drive(3'b001, 1, 0, 0, 32'h11, 0, 0, 1'b0);
    @(negedge clk);
    drive(3'b100, 0, 0, 7, 0, 0, 32'h77, 1'b0);
    #1;
    chk("mr_ready", src_ready, 3'b100);
    @(posedge clk);
    #1;
    chk("mr_en_pre", rf_write_en, 1);
    chk("mr_add_pre", rf_write_add, 7);
    drive(3'b111, 1, 2, 3, 0, 0, 0, 1'b0);
    reset = 1'b1;
    #1;
    chk("mr_en_async", rf_write_en, 0);
    chk("mr_add_clr", rf_write_add, 0);
    chk("mr_ready_rst", src_ready, 0);
    @(negedge clk);
    reset = 1'b0;
    #1;
    chk("mr_ptr0", src_ready, 3'b001);

    // Randomized run against a queue-free source model.
    do_reset();
    mv = '0;
    mptr = 0;
    m_add = '0; m_dat = '0; m_gid = '0;
    max_wait = 0;
    for (int i = 0; i < NS; i++) wait_c[i] = 0;
    for (int cyc = 0; cyc < 400; cyc++) begin
      int w;
      logic h;
      logic [2:0] er;
      if (cyc != 0) @(negedge clk);
      for (int i = 0; i < NS; i++) begin
        if (!mv[i] && ($urandom_range(1) == 1)) begin
          mv[i] = 1'b1;
          rq[i].addr = ($urandom_range(3) == 0) ? 5'd0
                       : 5'($urandom_range(31));
          rq[i].data = $urandom;
        end
      end
      h = ($urandom_range(4) == 0);
      drive(mv, rq[0].addr, rq[1].addr, rq[2].addr,
            rq[0].data, rq[1].data, rq[2].data, h);
      w = -1;
      if (!h) begin
        for (int k = 0; k < NS; k++) begin
          if (w < 0 && mv[(mptr + k) % NS]) w = (mptr + k) % NS;
        end
      end
      er = (w >= 0) ? 3'(1 << w) : 3'b000;
      #1;
      chk("rnd_ready", src_ready, er);
      for (int i = 0; i < NS; i++) begin
        if (mv[i] && !h && i != w) wait_c[i]++;
        if (wait_c[i] > max_wait) max_wait = wait_c[i];
      end
      @(posedge clk);
      #1;
      if (w >= 0) begin
        m_add = rq[w].addr;
        m_dat = rq[w].data;
        m_gid = 2'(w);
        mv[w] = 1'b0;
        wait_c[w] = 0;
        mptr = (w + 1) % NS;
      end
      chk("rnd_en", rf_write_en, (w >= 0) && (m_add != 0));
      chk("rnd_x0", x0_drop, (w >= 0) && (m_add == 0));
      chk("rnd_add", rf_write_add, m_add);
      chk("rnd_data", rf_write_data, m_dat);
      chk("rnd_gid", grant_id, m_gid);
    end
    chk("fair_wait_le", max_wait < NS, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout actual=running required=done");
    $fatal(1);
  end

endmodule
